// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment digit scanner: a prescaler paces digit-select stepping,
// with optional anode blanking after every step or load to suppress ghosting.
module fnd_scan_ctrl #(
    parameter int N_DIGITS  = 6,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 4,
    localparam int SEL_W    = ($clog2(N_DIGITS) > 1) ? $clog2(N_DIGITS) : 1,
    localparam int PS_W     = $clog2(TICK_DIV)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic                i_dir,
    input  logic                i_load,
    input  logic [SEL_W-1:0]    i_load_val,
    output logic [SEL_W-1:0]    o_sel,
    output logic [N_DIGITS-1:0] o_an,
    output logic                o_tick,
    output logic                o_wrap,
    output logic                o_blank
);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  ps_next;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] sel_step;
    logic [SEL_W-1:0] load_sel;
    logic             at_edge;

    assign o_tick  = !reset && i_en && !i_load && (ps == PS_LAST);
    assign at_edge = i_dir ? (sel == '0) : (sel == SEL_LAST);
    assign o_wrap  = o_tick && at_edge;

    // Out-of-range load values fall back to digit 0 so o_sel stays legal.
    assign load_sel = ({1'b0, i_load_val} >= (SEL_W + 1)'(N_DIGITS)) ? '0 : i_load_val;

    always_comb begin
        sel_step = sel;
        if (i_dir) begin
            sel_step = (sel == '0) ? SEL_LAST : sel - 1'b1;
        end else begin
            sel_step = (sel == SEL_LAST) ? '0 : sel + 1'b1;
        end
    end

    always_comb begin
        ps_next  = ps;
        sel_next = sel;
        if (i_load) begin
            ps_next  = '0;
            sel_next = load_sel;
        end else if (i_en) begin
            ps_next = (ps == PS_LAST) ? '0 : ps + 1'b1;
            if (o_tick) begin
                sel_next = sel_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps  <= '0;
            sel <= '0;
        end else begin
            ps  <= ps_next;
            sel <= sel_next;
        end
    end

    generate
        if (BLANK_CYC > 0) begin : g_blank
            assign o_blank = (ps < PS_W'(BLANK_CYC));
        end else begin : g_no_blank
            assign o_blank = 1'b0;
        end
    endgenerate

    always_comb begin
        o_an = '1;
        if (!o_blank) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                o_an[i] = (sel != SEL_W'(i));
            end
        end
    end

    assign o_sel = sel;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed scenarios plus random traffic, checked each cycle
// against an arithmetic reference model; a second instance runs without blanking.
module tb_fnd_scan_ctrl;

    localparam int N    = 6;
    localparam int TDIV = 4;
    localparam int BLNK = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_en, i_dir, i_load;
    logic [2:0] i_load_val;
    logic [2:0] o_sel, o_sel0;
    logic [5:0] o_an, o_an0;
    logic       o_tick, o_wrap, o_blank;
    logic       o_tick0, o_wrap0, o_blank0;

    int n_checks = 0;
    int n_errors = 0;
    int m_ps, m_sel;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TDIV), .BLANK_CYC(BLNK)) dut (
        .clk(clk), .reset(reset), .i_en(i_en), .i_dir(i_dir), .i_load(i_load),
        .i_load_val(i_load_val), .o_sel(o_sel), .o_an(o_an), .o_tick(o_tick),
        .o_wrap(o_wrap), .o_blank(o_blank)
    );

    fnd_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TDIV), .BLANK_CYC(0)) dut_nb (
        .clk(clk), .reset(reset), .i_en(i_en), .i_dir(i_dir), .i_load(i_load),
        .i_load_val(i_load_val), .o_sel(o_sel0), .o_an(o_an0), .o_tick(o_tick0),
        .o_wrap(o_wrap0), .o_blank(o_blank0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic en, input logic dir,
                        input logic ld, input logic [2:0] lv);
        logic       e_tick, e_wrap, e_blank;
        logic [5:0] e_an, e_an0;
        reset = rst; i_en = en; i_dir = dir; i_load = ld; i_load_val = lv;
        @(negedge clk);
        e_tick  = !rst && en && !ld && (m_ps == TDIV - 1);
        e_wrap  = e_tick && (dir ? (m_sel == 0) : (m_sel == N - 1));
        e_blank = (m_ps < BLNK);
        e_an0   = ~(6'b1 << m_sel);
        e_an    = e_blank ? 6'h3f : e_an0;
        check_val("tick",   32'(o_tick),   32'(e_tick));
        check_val("wrap",   32'(o_wrap),   32'(e_wrap));
        check_val("sel",    32'(o_sel),    32'(m_sel));
        check_val("blank",  32'(o_blank),  32'(e_blank));
        check_val("an",     32'(o_an),     32'(e_an));
        check_val("tick0",  32'(o_tick0),  32'(e_tick));
        check_val("wrap0",  32'(o_wrap0),  32'(e_wrap));
        check_val("sel0",   32'(o_sel0),   32'(m_sel));
        check_val("blank0", 32'(o_blank0), 32'd0);
        check_val("an0",    32'(o_an0),    32'(e_an0));
        @(posedge clk);
        if (rst) begin
            m_ps = 0; m_sel = 0;
        end else if (ld) begin
            m_ps  = 0;
            m_sel = (int'(lv) < N) ? int'(lv) : 0;
        end else if (en) begin
            if (e_tick) m_sel = dir ? (m_sel + N - 1) % N : (m_sel + 1) % N;
            m_ps = (m_ps + 1) % TDIV;
        end
        #1;
    endtask

    task automatic run(input int cycles, input logic en, input logic dir);
        for (int k = 0; k < cycles; k++) step(1'b0, en, dir, 1'b0, 3'd0);
    endtask

    initial begin
        logic dir_r;
        reset = 1'b1; i_en = 1'b0; i_dir = 1'b0; i_load = 1'b0; i_load_val = '0;
        @(posedge clk); #1;
        m_ps = 0; m_sel = 0;
        check_val("rst_sel", 32'(o_sel), 32'd0);
        check_val("rst_an",  32'(o_an),  32'h3f);
        check_val("rst_an0", 32'(o_an0), 32'h3e);

        // Full upward scan with wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(28, 1'b1, 1'b0);

        // Downward from digit 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(12, 1'b1, 1'b1);
        check_val("down_sel", 32'(o_sel), 32'd3);

        // Hold at prescaler 2, then resume.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(2, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        check_val("hold_sel", 32'(o_sel), 32'd0);
        run(5, 1'b1, 1'b0);
        check_val("resume_sel", 32'(o_sel), 32'd1);

        // Load coinciding with a tick, then an out-of-range load.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
        check_val("load3", 32'(o_sel), 32'd3);
        run(5, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        check_val("load7", 32'(o_sel), 32'd0);
        run(3, 1'b1, 1'b0);

        // Reset beats a coincident load.
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        check_val("rst_ld", 32'(o_sel), 32'd0);
        run(4, 1'b1, 1'b0);

        dir_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) dir_r = ~dir_r;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, dir_r,
                 $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of digits scanned; legal range 2..16.
REQ-002 SHALL have parameter TICK_DIV, default 100000, clk cycles per digit step; legal range >= 2.
REQ-003 SHALL have parameter BLANK_CYC, default 4, anode-off cycles after each step; legal range 0..TICK_DIV-1.
REQ-004 SHALL derive SEL_W = max(1, clog2(N_DIGITS)) and PS_W = clog2(TICK_DIV).
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: i_en  input  1  1 = prescaler runs; 0 = prescaler and o_sel hold.
REQ-008 SHALL have port: i_dir  input  1  step direction; 0 = up, 1 = down.
REQ-009 SHALL have port: i_load  input  1  single-cycle request to load i_load_val into o_sel.
REQ-010 SHALL have port: i_load_val  input  SEL_W  digit index to load.
REQ-011 SHALL have port: o_sel  output  SEL_W  current digit index.
REQ-012 SHALL have port: o_an  output  N_DIGITS  active-low one-hot anode enables.
REQ-013 SHALL have port: o_tick  output  1  step strobe.
REQ-014 SHALL have port: o_wrap  output  1  wrap-around strobe.
REQ-015 SHALL have port: o_blank  output  1  1 while anodes are forced off.

Function
REQ-016 SHALL hold an internal prescaler counting 0..TICK_DIV-1; with i_en=1 it increments each cycle, and from TICK_DIV-1 it returns to 0.
REQ-017 SHALL assert o_tick (comb.) exactly when prescaler==TICK_DIV-1 and i_en=1 and i_load=0 and reset=0; o_tick is one cycle wide.
REQ-018 SHALL, on the edge ending an o_tick cycle, step o_sel: up: N_DIGITS-1 -> 0, else +1; down: 0 -> N_DIGITS-1, else -1; o_sel never leaves 0..N_DIGITS-1.
REQ-019 SHALL assert o_wrap in the same cycle as o_tick iff that step wraps (up from N_DIGITS-1 or down from 0); otherwise o_wrap=0.
REQ-020 SHALL, with i_en=0, freeze prescaler and o_sel; on re-enable the prescaler resumes from its held value (no lost or extra cycles).
REQ-021 SHALL give i_load priority over a coincident tick: o_sel <= i_load_val (or 0 if i_load_val >= N_DIGITS), prescaler <= 0, no o_tick/o_wrap that cycle; i_load acts regardless of i_en.
REQ-022 SHALL assert o_blank when BLANK_CYC>0 and prescaler < BLANK_CYC; o_blank stays 0 permanently when BLANK_CYC=0.
REQ-023 SHALL drive o_an all ones while o_blank=1, else o_an[o_sel]=0 and all other bits 1.
REQ-024 SHALL derive o_sel, o_an and o_blank from registered state only; no combinational path from i_* to those outputs.
REQ-025 SHALL treat an i_dir change as taking effect at the next tick only; no other side effect.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set prescaler=0 and o_sel=0; o_tick=0 and o_wrap=0 while reset=1.
REQ-027 SHALL give reset priority over i_load, i_en and tick in the same cycle.
REQ-028 SHALL present after reset: o_blank = (BLANK_CYC>0), o_an = all ones if BLANK_CYC>0 else ~1 (digit 0 on).

Verification (N_DIGITS=6, TICK_DIV=4, BLANK_CYC=1 unless stated)
REQ-029 SHALL cover: reset, then i_en=1, i_dir=0 -> o_sel 0,1,2,3,4,5,0 changing every 4 cycles; o_tick every 4th cycle; o_wrap only with the tick at o_sel=5.
REQ-030 SHALL cover: from o_sel=0, i_dir=1 -> next step gives o_sel=5 with o_wrap=1, then 4,3.
REQ-031 SHALL cover: i_en=0 for 10 cycles at prescaler=2 -> o_sel and o_an unchanged; after re-enable the tick occurs exactly 1 cycle later.
REQ-032 SHALL cover: i_load=1, i_load_val=3 in a tick cycle -> o_sel=3, o_tick=0, o_wrap=0, next tick 4 cycles later; i_load_val=7 -> o_sel=0.
REQ-033 SHALL cover: blanking -> o_an=6'b111111 with o_blank=1 for 1 cycle after each step/load, then 6'b111110 at o_sel=0, 6'b111101 at o_sel=1; rerun with BLANK_CYC=0 -> o_blank never 1.
REQ-034 SHALL cover: reset=1 coincident with i_load=1 at o_sel=4 -> o_sel=0, prescaler=0, o_tick=0, o_wrap=0.
